// File: rtl/menu_pkg.sv
// Shared types and slice-offset helpers for the menu/game session controller.
package menu_pkg;

  // Session state: menu browsing, game reset/launch, play, and return to menu.
  typedef enum logic [1:0] {
    MENU   = 2'd0,
    LAUNCH = 2'd1,
    PLAY   = 2'd2,
    LEAVE  = 2'd3
  } state_t;

  // Bit offset of game idx inside the packed {R,G,B} video bus.
  function automatic int rgb_off(input int idx, input int rgb_w);
    return idx * 3 * rgb_w;
  endfunction

  // Bit offset of game idx inside the packed audio bus.
  function automatic int aud_off(input int idx, input int audio_w);
    return idx * audio_w;
  endfunction

endpackage

// File: rtl/menu_cursor.sv
// Menu cursor: up/down/home navigation over NUM_GAMES entries with a
// saturate-or-wrap option; only moves while enabled.
module menu_cursor #(
  parameter int NUM_GAMES = 5,
  parameter int WRAP      = 0,
  parameter int IDX_W     = $clog2(NUM_GAMES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_home,
  output logic [IDX_W-1:0] cursor
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_GAMES - 1);

  // Cursor register; home wins over moves, up+down together cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value, independent of statement order.
      cursor <= '0;
    end else if (en) begin
      if (key_home) begin
        cursor <= '0;
      end else if (key_up && !key_down) begin
        if (cursor == '0) cursor <= (WRAP != 0) ? LAST : '0;
        else              cursor <= cursor - 1'b1;
      end else if (key_down && !key_up) begin
        if (cursor == LAST) cursor <= (WRAP != 0) ? '0 : LAST;
        else                cursor <= cursor + 1'b1;
      end
    end
  end

endmodule

// File: rtl/menu_session_ctrl.sv
// Top-level menu/game session controller: cursor, timed game reset and start
// pulse, exit handling, and registered video/audio output mux.
module menu_session_ctrl
  import menu_pkg::*;
#(
  parameter int NUM_GAMES  = 5,
  parameter int RGB_W      = 4,
  parameter int AUDIO_W    = 3,
  parameter int WRAP       = 0,
  parameter int RST_CYCLES = 16,
  parameter int IDX_W      = $clog2(NUM_GAMES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_up,
  input  logic                           key_down,
  input  logic                           key_enter,
  input  logic                           key_exit,
  input  logic [NUM_GAMES-1:0]           game_over,
  input  logic                           frame_start,
  input  logic [3*RGB_W-1:0]             menu_rgb,
  input  logic [NUM_GAMES*3*RGB_W-1:0]   game_rgb,
  input  logic [AUDIO_W-1:0]             menu_audio,
  input  logic [NUM_GAMES*AUDIO_W-1:0]   game_audio,
  output logic [IDX_W-1:0]               cursor,
  output logic [IDX_W-1:0]               active,
  output logic                           in_game,
  output logic [NUM_GAMES-1:0]           game_rst,
  output logic [NUM_GAMES-1:0]           game_start,
  output logic [3*RGB_W-1:0]             rgb_out,
  output logic [AUDIO_W-1:0]             audio_out
);

  localparam int RGB_BITS = 3 * RGB_W;
  localparam int CNT_W    = $clog2(RST_CYCLES + 1);
  localparam logic [NUM_GAMES-1:0] ONE_HOT0 = NUM_GAMES'(1);

  state_t                state;
  logic [CNT_W-1:0]      rst_cnt;
  logic                  cursor_en;
  logic [RGB_BITS-1:0]   game_pix;
  logic [AUDIO_W-1:0]    game_aud;
  logic                  game_over_act;

  // Cursor only moves while browsing; enter freezes it in its launch cycle.
  assign cursor_en = (state == MENU) && !key_enter;

  menu_cursor #(
    .NUM_GAMES (NUM_GAMES),
    .WRAP      (WRAP),
    .IDX_W     (IDX_W)
  ) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .en       (cursor_en),
    .key_up   (key_up),
    .key_down (key_down),
    .key_home (key_exit),
    .cursor   (cursor)
  );

  // Select the active game's video, audio and game-over flag.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    game_pix      = '0;
    game_aud      = '0;
    game_over_act = 1'b0;
    for (int i = 0; i < NUM_GAMES; i++) begin
      if (active == IDX_W'(i)) begin
        game_pix      = game_rgb[rgb_off(i, RGB_W) +: RGB_BITS];
        game_aud      = game_audio[aud_off(i, AUDIO_W) +: AUDIO_W];
        game_over_act = game_over[i];
      end
    end
  end

  // Session FSM with registered control outputs and output mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MENU;
      rst_cnt    <= '0;
      active     <= '0;
      in_game    <= 1'b0;
      game_rst   <= '1;
      game_start <= '0;
      rgb_out    <= '0;
      audio_out  <= '0;
    end else begin
      game_start <= '0;
      case (state)
        MENU: begin
          rgb_out   <= menu_rgb;
          audio_out <= menu_audio;
          if (key_enter) begin
            active  <= cursor;
            rst_cnt <= CNT_W'(RST_CYCLES);
            state   <= LAUNCH;
          end
        end

        LAUNCH: begin
          rgb_out   <= menu_rgb;
          audio_out <= '0;
          if (rst_cnt != '0) begin
            // A frame_start during the last counted cycle is not taken.
            rst_cnt <= rst_cnt - 1'b1;
            if (rst_cnt == CNT_W'(1)) game_rst <= ~(ONE_HOT0 << active);
          end else if (frame_start) begin
            state      <= PLAY;
            in_game    <= 1'b1;
            game_start <= ONE_HOT0 << active;
          end
        end

        PLAY: begin
          rgb_out   <= game_pix;
          audio_out <= game_aud;
          if (key_exit || game_over_act) begin
            state    <= LEAVE;
            in_game  <= 1'b0;
            game_rst <= '1;
          end
        end

        LEAVE: begin
          rgb_out   <= game_pix;
          audio_out <= '0;
          if (frame_start) state <= MENU;
        end

        default: state <= MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_session_ctrl.sv
// Bench for menu_session_ctrl: one saturating (WRAP=0) and one wrapping
// (WRAP=1) instance driven with identical stimulus and compared every cycle
// against a behavioural session model, plus table vectors and directed
// launch / exit / reset sequences.
module tb_menu_session_ctrl;

  localparam int N  = 5;
  localparam int RW = 4;
  localparam int AW = 3;
  localparam int R  = 16;
  localparam int IW = $clog2(N);
  localparam int PB = 3 * RW;

  localparam int M_MENU   = 0;
  localparam int M_LAUNCH = 1;
  localparam int M_PLAY   = 2;
  localparam int M_LEAVE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_up, key_down, key_enter, key_exit, frame_start;
  logic [N-1:0]     game_over;
  logic [PB-1:0]    menu_rgb;
  logic [N*PB-1:0]  game_rgb;
  logic [AW-1:0]    menu_audio;
  logic [N*AW-1:0]  game_audio;

  logic [IW-1:0] cursor_o   [2];
  logic [IW-1:0] active_o   [2];
  logic          in_game_o  [2];
  logic [N-1:0]  game_rst_o [2];
  logic [N-1:0]  game_start_o [2];
  logic [PB-1:0] rgb_o      [2];
  logic [AW-1:0] audio_o    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  menu_session_ctrl #(.NUM_GAMES(N), .RGB_W(RW), .AUDIO_W(AW), .WRAP(0), .RST_CYCLES(R)) dut_sat (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
    .key_exit(key_exit), .game_over(game_over), .frame_start(frame_start),
    .menu_rgb(menu_rgb), .game_rgb(game_rgb), .menu_audio(menu_audio), .game_audio(game_audio),
    .cursor(cursor_o[0]), .active(active_o[0]), .in_game(in_game_o[0]), .game_rst(game_rst_o[0]),
    .game_start(game_start_o[0]), .rgb_out(rgb_o[0]), .audio_out(audio_o[0]));

  menu_session_ctrl #(.NUM_GAMES(N), .RGB_W(RW), .AUDIO_W(AW), .WRAP(1), .RST_CYCLES(R)) dut_wrap (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
    .key_exit(key_exit), .game_over(game_over), .frame_start(frame_start),
    .menu_rgb(menu_rgb), .game_rgb(game_rgb), .menu_audio(menu_audio), .game_audio(game_audio),
    .cursor(cursor_o[1]), .active(active_o[1]), .in_game(in_game_o[1]), .game_rst(game_rst_o[1]),
    .game_start(game_start_o[1]), .rgb_out(rgb_o[1]), .audio_out(audio_o[1]));

  // Behavioural model of one session: mode, cursor, launched game, cycles
  // spent in the current mode, and the values the registered outputs hold.
  typedef struct {
    int           mode;
    int           cur;
    int           act;
    int           age;
    logic [PB-1:0] rgb;
    logic [AW-1:0] aud;
    logic [N-1:0]  start;
  } mdl_t;

  mdl_t m[2];
  int   wrap_of[2] = '{0, 1};

  typedef struct {
    logic up;
    logic down;
    logic exit_k;
    int   cur_sat;
    int   cur_wrap;
  } nav_vec_t;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].mode = M_MENU; m[i].cur = 0; m[i].act = 0; m[i].age = 0;
      m[i].rgb = '0; m[i].aud = '0; m[i].start = '0;
    end
  endtask

  // Advance model i by one clock, using the inputs held during that cycle.
  task automatic model_step(input int i);
    int pm;
    pm = m[i].mode;
    m[i].rgb   = (pm == M_PLAY || pm == M_LEAVE) ? game_rgb[m[i].act*PB +: PB] : menu_rgb;
    m[i].aud   = (pm == M_MENU) ? menu_audio :
                 (pm == M_PLAY) ? game_audio[m[i].act*AW +: AW] : '0;
    m[i].start = '0;
    case (pm)
      M_MENU: begin
        if (key_enter) begin
          m[i].act = m[i].cur; m[i].mode = M_LAUNCH; m[i].age = 1;
        end else if (key_exit) begin
          m[i].cur = 0;
        end else if (key_up && !key_down) begin
          if (wrap_of[i] != 0) m[i].cur = (m[i].cur + N - 1) % N;
          else if (m[i].cur > 0) m[i].cur = m[i].cur - 1;
        end else if (key_down && !key_up) begin
          if (wrap_of[i] != 0) m[i].cur = (m[i].cur + 1) % N;
          else if (m[i].cur < N - 1) m[i].cur = m[i].cur + 1;
        end
      end
      M_LAUNCH: begin
        if (m[i].age > R && frame_start) begin
          m[i].mode = M_PLAY; m[i].start = N'(1) << m[i].act;
        end else begin
          m[i].age = m[i].age + 1;
        end
      end
      M_PLAY:  if (key_exit || game_over[m[i].act]) m[i].mode = M_LEAVE;
      default: if (frame_start) m[i].mode = M_MENU;
    endcase
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_rst;
    for (int i = 0; i < 2; i++) begin
      exp_rst = '1;
      if ((m[i].mode == M_LAUNCH && m[i].age > R) || m[i].mode == M_PLAY) exp_rst[m[i].act] = 1'b0;
      check($sformatf("dut%0d cursor", i),     64'(cursor_o[i]),     64'(m[i].cur));
      check($sformatf("dut%0d cursor_range", i), 64'(cursor_o[i] < IW'(N)), 64'(1));
      check($sformatf("dut%0d active", i),     64'(active_o[i]),     64'(m[i].act));
      check($sformatf("dut%0d in_game", i),    64'(in_game_o[i]),    64'(m[i].mode == M_PLAY));
      check($sformatf("dut%0d game_rst", i),   64'(game_rst_o[i]),   64'(exp_rst));
      check($sformatf("dut%0d game_start", i), 64'(game_start_o[i]), 64'(m[i].start));
      check($sformatf("dut%0d rgb_out", i),    64'(rgb_o[i]),        64'(m[i].rgb));
      check($sformatf("dut%0d audio_out", i),  64'(audio_o[i]),      64'(m[i].aud));
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_idle();
    key_up = 0; key_down = 0; key_enter = 0; key_exit = 0;
    frame_start = 0; game_over = '0;
    menu_rgb   = PB'($urandom);
    game_rgb   = (N*PB)'({$urandom, $urandom});
    menu_audio = AW'($urandom);
    game_audio = (N*AW)'($urandom);
  endtask

  initial begin
    nav_vec_t nav[12];
    int hi_cnt;
    logic [PB-1:0] exp_rgb;

    nav[0]  = '{0, 1, 0, 1, 1};
    nav[1]  = '{0, 1, 0, 2, 2};
    nav[2]  = '{0, 1, 0, 3, 3};
    nav[3]  = '{0, 1, 0, 4, 4};
    nav[4]  = '{0, 1, 0, 4, 0};
    nav[5]  = '{0, 1, 0, 4, 1};
    nav[6]  = '{1, 0, 0, 3, 0};
    nav[7]  = '{1, 1, 0, 3, 0};
    nav[8]  = '{0, 0, 1, 0, 0};
    nav[9]  = '{1, 0, 0, 0, 4};
    nav[10] = '{0, 1, 0, 1, 0};
    nav[11] = '{0, 1, 0, 2, 1};

    drive_idle();
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;

    // Cursor navigation, both saturate and wrap instances.
    for (int v = 0; v < 12; v++) begin
      drive_idle();
      key_up = nav[v].up; key_down = nav[v].down; key_exit = nav[v].exit_k;
      cycle();
      check($sformatf("nav%0d cursor_sat", v),  64'(cursor_o[0]), 64'(nav[v].cur_sat));
      check($sformatf("nav%0d cursor_wrap", v), 64'(cursor_o[1]), 64'(nav[v].cur_wrap));
    end

    // Enter and down together: launch the old cursor, cursor stays.
    drive_idle();
    key_enter = 1; key_down = 1;
    cycle();
    check("prio active", 64'(active_o[0]), 64'(2));
    check("prio cursor", 64'(cursor_o[0]), 64'(2));

    // Reset pulse length, with a frame_start on the final counted cycle.
    hi_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (game_rst_o[0][2]) hi_cnt++;
      if (k == 1 || k == 20) check($sformatf("launch others k%0d", k), 64'(game_rst_o[0] | 5'b00100), 64'(5'b11111));
      if (k == 17) check("launch late frame ignored", 64'(in_game_o[0]), 64'(0));
      drive_idle();
      frame_start = (k == 16);
      cycle();
    end
    check("launch rst cycles", 64'(hi_cnt), 64'(R));

    drive_idle();
    frame_start = 1;
    cycle();
    check("launch game_start", 64'(game_start_o[0]), 64'(5'b00100));
    check("launch in_game", 64'(in_game_o[0]), 64'(1));
    drive_idle();
    exp_rgb = game_rgb[2*PB +: PB];
    cycle();
    check("play rgb game2", 64'(rgb_o[0]), 64'(exp_rgb));
    check("play start cleared", 64'(game_start_o[0]), 64'(0));

    // Exit paths: foreign game_over ignored, own game_over leaves.
    for (int k = 0; k < 3; k++) begin
      drive_idle();
      game_over = 5'b01000;
      cycle();
      check("foreign game_over", 64'(in_game_o[0]), 64'(1));
    end
    drive_idle();
    game_over = 5'b00100;
    cycle();
    check("leave in_game", 64'(in_game_o[0]), 64'(0));
    check("leave game_rst2", 64'(game_rst_o[0][2]), 64'(1));
    drive_idle();
    cycle();
    check("leave audio", 64'(audio_o[0]), 64'(0));
    drive_idle();
    frame_start = 1;
    cycle();
    check("menu cursor kept", 64'(cursor_o[0]), 64'(2));
    drive_idle();
    exp_rgb = menu_rgb;
    cycle();
    check("menu rgb", 64'(rgb_o[0]), 64'(exp_rgb));

    // Asynchronous reset in the middle of LAUNCH.
    drive_idle();
    key_enter = 1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive_idle();
      cycle();
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async rst game_rst", 64'(game_rst_o[0]), 64'(5'b11111));
    check("async rst rgb", 64'(rgb_o[0]), 64'(0));
    drive_idle();
    cycle();
    rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      drive_idle();
      frame_start = (k % 5 == 0);
      cycle();
      check("post rst no start", 64'(game_start_o[0] | game_start_o[1]), 64'(0));
    end

    // Randomised sessions against the model.
    for (int k = 0; k < 4000; k++) begin
      drive_idle();
      key_up      = ($urandom_range(0, 5) == 0);
      key_down    = ($urandom_range(0, 5) == 0);
      key_enter   = ($urandom_range(0, 9) == 0);
      key_exit    = ($urandom_range(0, 29) == 0);
      frame_start = ($urandom_range(0, 9) == 0);
      game_over   = ($urandom_range(0, 29) == 0) ? N'($urandom) : '0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
